// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter that shares one 4-bit binary-to-Gray
// converter among 2**ID_W requesters. The winning requester's word is
// converted and registered together with its index. Results leave through a
// valid/ready handshake, and a fresh grant can reload the output register on
// the same edge that the consumer accepts the previous result.

// bin_gray_4_bit: 4-bit binary-to-Gray converter.
// {a,b,c,d} is the binary word MSB first. {w,x,y,z} is the Gray word MSB first.
module bin_gray_4_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic w,
    output logic x,
    output logic y,
    output logic z
);

    // Each Gray bit is the XOR of a binary bit and its more significant neighbour.
    assign w = a;
    assign x = a ^ b;
    assign y = b ^ c;
    assign z = c ^ d;

endmodule

module gray_conv_arbiter #(
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**ID_W-1:0]    req,
    input  logic [4*(2**ID_W)-1:0] req_bin,
    output logic [2**ID_W-1:0]    ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_gray,
    output logic [ID_W-1:0]       out_id
);

    localparam int N = 2**ID_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            grant;
    logic [3:0]      sel_bin;
    logic [3:0]      gray_res;
    logic [N-1:0]    grant_onehot;

    // Rotating priority search: scan ptr, ptr+1, ... and take the first active request.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + ID_W'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Route the candidate winner's word into the single shared converter.
    assign sel_bin      = req_bin[{winner, 2'b00} +: 4];
    assign grant_onehot = {{(N-1){1'b0}}, 1'b1} << winner;

    bin_gray_4_bit u_conv (
        .a (sel_bin[3]),
        .b (sel_bin[2]),
        .c (sel_bin[1]),
        .d (sel_bin[0]),
        .w (gray_res[3]),
        .x (gray_res[2]),
        .y (gray_res[1]),
        .z (gray_res[0])
    );

    // Grant when the output register is empty, or when the consumer frees it this edge.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant      = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (found) begin
                        grant = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; HOLD is exactly the "result pending" condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign out_valid = (state == HOLD);

    // Result register, one-cycle ack pulse and round-robin pointer update on each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            out_gray <= '0;
            out_id   <= '0;
            ack      <= '0;
        end else if (grant) begin
            ptr      <= winner + ID_W'(1);
            out_gray <= gray_res;
            out_id   <= winner;
            ack      <= grant_onehot;
        end else begin
            ack      <= '0;
        end
    end

endmodule
